// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a 16-bit subtractive GCD datapath.
// Ports: clk, rst (async high), start, in_valid/in_ready operand handshake,
//   lt/gt/eq compare flags in; lda/ldb, sel1/sel2/sel_in datapath controls,
//   busy/done/error status and iter_count out.
`timescale 1ns/1ps
module gcd_controller #(
   parameter int MAX_ITER = 65535,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             lt,
   input  logic             gt,
   input  logic             eq,
   output logic             lda,
   output logic             ldb,
   output logic             sel1,
   output logic             sel2,
   output logic             sel_in,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] iter_count
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      CALC,
      DONE,
      ERR
   } state_t;

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);

   state_t     state, state_nx;
   logic       cnt_clr;
   logic       cnt_inc;
   logic [1:0] flag_cnt;

   assign flag_cnt = {1'b0, lt} + {1'b0, gt} + {1'b0, eq};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Saturating counter; the timeout check normally stops loads first,
   // the guard keeps it from wrapping regardless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_count <= '0;
      end else if (cnt_clr) begin
         iter_count <= '0;
      end else if (cnt_inc && iter_count != MAX_C) begin
         iter_count <= iter_count + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      in_ready = 1'b0;
      lda      = 1'b0;
      ldb      = 1'b0;
      sel1     = 1'b0;
      sel2     = 1'b0;
      sel_in   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      error    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = LOAD_A;
               cnt_clr  = 1'b1;
            end
         end
         LOAD_A: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            sel_in   = 1'b1;
            if (in_valid) begin
               lda      = 1'b1;
               state_nx = LOAD_B;
            end
         end
         LOAD_B: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            sel_in   = 1'b1;
            if (in_valid) begin
               ldb      = 1'b1;
               state_nx = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            // Flags must be one-hot before they are trusted.
            if (flag_cnt != 2'd1) begin
               state_nx = ERR;
            end else if (eq) begin
               state_nx = DONE;
            end else if (iter_count == MAX_C) begin
               state_nx = ERR;
            end else if (gt) begin
               sel2    = 1'b1;
               lda     = 1'b1;
               cnt_inc = 1'b1;
            end else begin
               sel1    = 1'b1;
               ldb     = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nx = LOAD_A;
               cnt_clr  = 1'b1;
            end
         end
         ERR: begin
            error = 1'b1;
            if (start) begin
               state_nx = LOAD_A;
               cnt_clr  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed bench with a behavioural GCD datapath.
// Ports: none; drives gcd_controller (MAX_ITER=10) and checks status.
`timescale 1ns/1ps
module tb_gcd_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        lt, gt, eq;
   logic        lda, ldb, sel1, sel2, sel_in;
   logic        busy, done, error;
   logic [15:0] iter_count;

   logic [15:0] data_in = '0;
   logic [15:0] ra = '0;
   logic [15:0] rb = '0;
   logic [15:0] xo, yo, bus;
   logic        force_on = 1'b0;
   int          subs = 0;

   int errors = 0;
   int checks = 0;
   int edges;
   int s0;
   bit was_reset;

   always #5 clk = ~clk;

   gcd_controller #(.MAX_ITER(10), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .lt(lt), .gt(gt), .eq(eq),
      .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
      .busy(busy), .done(done), .error(error),
      .iter_count(iter_count)
   );

   // Behavioural datapath: x = minuend, y = subtrahend.
   always_comb begin
      xo  = sel1 ? rb : ra;
      yo  = sel2 ? rb : ra;
      bus = sel_in ? data_in : (xo - yo);
      if (force_on) begin
         lt = 1'b1;
         gt = 1'b1;
         eq = 1'b0;
      end else begin
         lt = ra < rb;
         gt = ra > rb;
         eq = ra == rb;
      end
   end

   always @(posedge clk) begin
      if (lda) ra <= bus;
      if (ldb) rb <= bus;
      if ((lda || ldb) && !sel_in) subs <= subs + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] outs();
      return {busy, done, error, in_ready, lda, ldb, sel1, sel2, sel_in};
   endfunction

   // Runs one GCD; edges counts clock edges after the accepting edge.
   task automatic run(input logic [15:0] a, input logic [15:0] b,
                      input int sa, input int sb, input bit bad,
                      input bit poke, input int rst_at);
      was_reset = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      s0 = subs;
      edges = 0;
      check("accept_ready", in_ready, 1);
      check("accept_done", {done, error}, 0);
      check("accept_iter", iter_count, 0);
      for (int i = 0; i < sa; i++) begin
         in_valid = 1'b0;
         #1 check("stall_a_load", {lda, ldb}, 0);
         @(posedge clk); #1 edges++;
      end
      data_in = a; in_valid = 1'b1;
      @(posedge clk); #1 edges++;
      for (int i = 0; i < sb; i++) begin
         in_valid = 1'b0;
         #1 check("stall_b_load", {lda, ldb}, 0);
         @(posedge clk); #1 edges++;
      end
      data_in = b; in_valid = 1'b1;
      @(posedge clk); #1 edges++;
      in_valid = 1'b0;
      if (bad) begin
         force_on = 1'b1;
         #1 check("bad_no_load", {lda, ldb}, 0);
      end
      for (int c = 0; c < 100; c++) begin
         if (done || error) break;
         if (rst_at > 0 && c == rst_at) begin
            check("pre_rst_iter", iter_count, rst_at);
            #3 rst = 1'b1;
            #1 check("rst_outs", outs(), 0);
            check("rst_iter", iter_count, 0);
            @(posedge clk); #1
            check("rst_hold", outs(), 0);
            @(negedge clk) rst = 1'b0;
            #1 check("rst_idle", outs(), 0);
            was_reset = 1'b1;
            break;
         end
         start = (poke && c == 2);
         @(posedge clk); #1 edges++;
         start = 1'b0;
      end
      if (!was_reset)
         check("finished", done || error, 1);
      force_on = 1'b0;
   endtask

   initial begin
      #2 check("rst_active_outs", outs(), 0);
      check("rst_active_iter", iter_count, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1
      check("idle_outs", outs(), 0);
      check("idle_iter", iter_count, 0);

      // 12,8: gt (A=4), lt (B=4), eq -> k=2, latency 4+k.
      run(16'd12, 16'd8, 0, 0, 1'b0, 1'b0, 0);
      check("basic_done", {done, error}, 2'b10);
      check("basic_iter", iter_count, 2);
      check("basic_lat", edges + 1, 6);
      check("basic_subs", subs - s0, 2);
      check("basic_ab", {ra, rb}, {16'd4, 16'd4});
      check("done_hold_outs", outs(), 9'b010000000);

      // Restart from DONE (run checks done drops and in_ready=1).
      run(16'd7, 16'd7, 0, 0, 1'b0, 1'b0, 0);
      check("eq_done", {done, error}, 2'b10);
      check("eq_iter", iter_count, 0);
      check("eq_lat", edges + 1, 4);
      check("eq_subs", subs - s0, 0);

      // 5,0: gt forever, times out after MAX_ITER=10 loads.
      run(16'd5, 16'd0, 0, 0, 1'b0, 1'b0, 0);
      check("zero_flags", {done, error}, 2'b01);
      check("zero_iter", iter_count, 10);
      check("zero_subs", subs - s0, 10);
      check("zero_lat", edges + 1, 14);

      // Stalls 3 + 2: same result, 5 extra cycles.
      run(16'd12, 16'd8, 3, 2, 1'b0, 1'b0, 0);
      check("stall_done", {done, error}, 2'b10);
      check("stall_iter", iter_count, 2);
      check("stall_lat", edges + 1, 11);
      check("stall_ab", {ra, rb}, {16'd4, 16'd4});

      // 30,4: seven gt then one lt, B=2; start pulsed mid-CALC.
      run(16'd30, 16'd4, 0, 0, 1'b0, 1'b1, 0);
      check("poke_done", {done, error}, 2'b10);
      check("poke_iter", iter_count, 8);
      check("poke_lat", edges + 1, 12);
      check("poke_ab", {ra, rb}, {16'd2, 16'd2});

      // Illegal flags lt=gt=1 on CALC entry.
      run(16'd20, 16'd6, 0, 0, 1'b1, 1'b0, 0);
      check("bad_err", {done, error}, 2'b01);
      check("bad_iter", iter_count, 0);
      check("bad_subs", subs - s0, 0);

      // Async reset three iterations into 65535,1.
      run(16'd65535, 16'd1, 0, 0, 1'b0, 1'b0, 3);
      check("rst_seen", was_reset, 1);
      check("rst_a_kept", ra, 16'd65532);

      // 9,6: A=3, then B=3 -> k=2.
      run(16'd9, 16'd6, 0, 0, 1'b0, 1'b0, 0);
      check("post_rst_done", {done, error}, 2'b10);
      check("post_rst_iter", iter_count, 2);
      check("post_rst_ab", {ra, rb}, {16'd3, 16'd3});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
